// File: rtl/tinybf_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tinybf_uart_pkg
// Description : Shared encodings and constants for the TinyBF UART input path.
//               Read FSM states, echo FSM states, default FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package tinybf_uart_pkg;

  // Default FIFO depth exponent: 2**2 = 4 bytes
  localparam int C_DEPTH_LOG2_DEFAULT = 2;

  // Read-side handshake FSM
  typedef enum logic [0:0] {
    RD_IDLE    = 1'b0,
    RD_RELEASE = 1'b1
  } rd_state_t;

  // Echo-to-transmitter FSM
  typedef enum logic [1:0] {
    E_IDLE  = 2'd0,
    E_START = 2'd1,
    E_GUARD = 2'd2
  } echo_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_byte_fifo
// Description : Synchronous byte FIFO, 2**DEPTH_LOG2 entries, head visible
//               combinationally. Push into a full FIFO is only accepted when
//               a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_byte_fifo
  import tinybf_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = C_DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [7:0]            i_data,
  input  logic                  i_pop,
  output logic [7:0]            o_head,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int C_DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            r_mem [C_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Count never exceeds the depth, so its MSB alone flags a full FIFO.
  assign w_full    = r_count[DEPTH_LOG2];
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage array write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Buffers bytes from the 8N1 UART receiver and serves the
//               TinyBF ',' read operation over a req/ack handshake. Sticky
//               overrun flag. Optional echo of every consumed byte to the
//               UART transmitter, enabled by defining UART_RX_ECHO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
  import tinybf_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = C_DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  input  logic                  rd_req_i,
  output logic [7:0]            rd_data_o,
  output logic                  rd_ack_o,
  output logic [DEPTH_LOG2:0]   fifo_count_o,
  output logic                  overrun_o,
  input  logic                  clr_overrun_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_start_o,
  input  logic                  tx_busy_i
);

  logic [7:0] w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_overrun_set;
  logic       w_echo_idle;

  rd_state_t  r_rd_state;
  rd_state_t  w_rd_state_nxt;
  logic [7:0] r_rd_data;
  logic       r_rd_ack;
  logic       r_overrun;

  // A byte may enter a full FIFO only when the head leaves in the same cycle.
  assign w_push        = rx_valid_i && (!w_full || w_pop);
  assign w_overrun_set = rx_valid_i && w_full && !w_pop;

  rx_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (w_push),
    .i_data  (rx_data_i),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (fifo_count_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Read FSM next state: pop once per request, then wait for req to drop
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_pop          = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (rd_req_i && !w_empty && w_echo_idle) begin
          w_pop          = 1'b1;
          w_rd_state_nxt = RD_RELEASE;
        end
      end
      RD_RELEASE: begin
        if (!rd_req_i) begin
          w_rd_state_nxt = RD_IDLE;
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= RD_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Registered read data and single-cycle acknowledge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_data <= 8'h00;
      r_rd_ack  <= 1'b0;
    end else begin
      r_rd_ack <= w_pop;
      if (w_pop) begin
        r_rd_data <= w_head;
      end
    end
  end

  // Sticky overrun; a new drop outranks a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun_i) begin
      r_overrun <= 1'b0;
    end
  end

  assign rd_data_o = r_rd_data;
  assign rd_ack_o  = r_rd_ack;
  assign overrun_o = r_overrun;

`ifdef UART_RX_ECHO_EN
  echo_state_t r_echo_state;
  echo_state_t w_echo_state_nxt;
  logic        r_guard_skip;
  logic        w_guard_skip_nxt;
  logic        w_tx_start_nxt;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;

  // Echo FSM next state: start when the transmitter is free, then skip one
  // cycle of tx_busy_i (it rises one cycle after start) before waiting idle
  always_comb begin
    w_echo_state_nxt = r_echo_state;
    w_guard_skip_nxt = r_guard_skip;
    w_tx_start_nxt   = 1'b0;
    case (r_echo_state)
      E_IDLE: begin
        if (w_pop) begin
          w_echo_state_nxt = E_START;
        end
      end
      E_START: begin
        if (!tx_busy_i) begin
          w_tx_start_nxt   = 1'b1;
          w_guard_skip_nxt = 1'b1;
          w_echo_state_nxt = E_GUARD;
        end
      end
      E_GUARD: begin
        if (r_guard_skip) begin
          w_guard_skip_nxt = 1'b0;
        end else if (!tx_busy_i) begin
          w_echo_state_nxt = E_IDLE;
        end
      end
      default: w_echo_state_nxt = E_IDLE;
    endcase
  end

  // Echo FSM registers and transmitter interface
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_echo_state <= E_IDLE;
      r_guard_skip <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'h00;
    end else begin
      r_echo_state <= w_echo_state_nxt;
      r_guard_skip <= w_guard_skip_nxt;
      r_tx_start   <= w_tx_start_nxt;
      if (w_pop) begin
        r_tx_data <= w_head;
      end
    end
  end

  assign w_echo_idle = (r_echo_state == E_IDLE);
  assign tx_data_o   = r_tx_data;
  assign tx_start_o  = r_tx_start;
`else
  logic w_unused_tx_busy;

  assign w_unused_tx_busy = tx_busy_i;
  assign w_echo_idle      = 1'b1;
  assign tx_data_o        = 8'h00;
  assign tx_start_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Scoreboard bench for uart_rx_ctrl (DEPTH_LOG2=2). A queue
//               model of the byte buffer predicts deliveries, counts and
//               overrun; a negedge monitor compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rd_req = 1'b0;
  logic         clr = 1'b0;
  logic         tx_busy = 1'b0;
  logic [7:0]   rd_data;
  logic         rd_ack;
  logic [DL2:0] count;
  logic         overrun;
  logic [7:0]   tx_data;
  logic         tx_start;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_data_i     (rx_data),
    .rx_valid_i    (rx_valid),
    .rd_req_i      (rd_req),
    .rd_data_o     (rd_data),
    .rd_ack_o      (rd_ack),
    .fifo_count_o  (count),
    .overrun_o     (overrun),
    .clr_overrun_i (clr),
    .tx_data_o     (tx_data),
    .tx_start_o    (tx_start),
    .tx_busy_i     (tx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];        // bytes buffered
  logic [7:0] exp_rd_q[$];   // bytes the core must receive, in order
  logic [7:0] exp_tx_q[$];   // bytes the transmitter must be asked to echo
  bit         m_served = 0;  // current request already served, req not yet dropped
  bit         m_overrun = 0;
  bit         m_ack_now = 0;
  bit         m_start_now = 0;
  int         m_echo = 0;    // 0 idle, 1 wait tx free, 2 guard, 3 wait tx done
  bit         m_pop;
  bit         m_drop;
  logic [7:0] m_b;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      exp_rd_q.delete();
      exp_tx_q.delete();
      m_served = 0; m_overrun = 0; m_ack_now = 0; m_start_now = 0; m_echo = 0;
    end else begin
      m_pop = !m_served && rd_req && (m_q.size() > 0) && (m_echo == 0);
      m_start_now = 0;
`ifdef UART_RX_ECHO_EN
      if (m_echo == 1 && !tx_busy) begin m_echo = 2; m_start_now = 1; end
      else if (m_echo == 2) m_echo = 3;
      else if (m_echo == 3 && !tx_busy) m_echo = 0;
`endif
      if (m_served && !rd_req) m_served = 0;
      m_ack_now = m_pop;
      if (m_pop) begin
        m_b = m_q.pop_front();
        exp_rd_q.push_back(m_b);
        m_served = 1;
`ifdef UART_RX_ECHO_EN
        exp_tx_q.push_back(m_b);
        m_echo = 1;
`endif
      end
      m_drop = 0;
      if (rx_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(rx_data);
        else m_drop = 1;
      end
      if (m_drop) m_overrun = 1;
      else if (clr) m_overrun = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("ack", 32'(rd_ack), 32'(m_ack_now));
    if (rd_ack === 1'b1) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_data: unexpected ack with data 0x%0h, none expected", rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
      end
    end
    chk("count", 32'(count), 32'(m_q.size()));
    chk("overrun", 32'(overrun), 32'(m_overrun));
    chk("tx_start", 32'(tx_start), 32'(m_start_now));
`ifdef UART_RX_ECHO_EN
    if (tx_start === 1'b1 && exp_tx_q.size() != 0)
      chk("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
`else
    chk("tx_data_const", 32'(tx_data), 32'h0);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_ack(output logic [7:0] d);
    bit seen;
    seen = 0; d = 8'h00;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (rd_ack === 1'b1) begin seen = 1; d = rd_data; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no rd_ack_o within 50 cycles, required one");
    end
  endtask

  task automatic read_byte(input bit hold, output logic [7:0] d);
    rd_req = 1'b1;
    wait_ack(d);
    if (hold) @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] d;
    bit hold;
    bit seen;

    repeat (2) @(negedge clk);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_ack", 32'(rd_ack), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte then read
    push_byte(8'h41);
    chk("t2_count_before", 32'(count), 32'd1);
    read_byte(1'b0, d);
    chk("t2_data", 32'(d), 32'h41);
    chk("t2_count_after", 32'(count), 32'd0);

    // Request pending on empty FIFO, byte arrives later
    rd_req = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_no_ack_while_empty", 32'(rd_ack), 32'h0);
    rx_data = 8'h2B; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("t3_ack_not_same_cycle", 32'(rd_ack), 32'h0);
    @(negedge clk);
    chk("t3_ack_next_cycle", 32'(rd_ack), 32'h1);
    chk("t3_data", 32'(rd_data), 32'h2B);
    rd_req = 1'b0;
    @(negedge clk);

    // Overfill: fifth byte dropped
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    chk("t4_overrun", 32'(overrun), 32'h1);
    chk("t4_count_full", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      read_byte(1'(i % 2), d);
      chk("t4_data", 32'(d), 32'(i));
    end
    chk("t4_count_empty", 32'(count), 32'd0);
    chk("t4_overrun_sticky", 32'(overrun), 32'h1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t4_overrun_cleared", 32'(overrun), 32'h0);

    // Full FIFO, push and pop in the same cycle
    for (int i = 0; i < 4; i++) push_byte(8'h11 + 8'(i));
    rd_req = 1'b1; rx_data = 8'h15; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rd_req = 1'b0;
    chk("t5_ack", 32'(rd_ack), 32'h1);
    chk("t5_data", 32'(rd_data), 32'h11);
    chk("t5_count", 32'(count), 32'd4);
    chk("t5_no_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      read_byte(1'b0, d);
      chk("t5_order", 32'(d), 32'h12 + 32'(i));
    end

    // Reset while in the release phase with bytes buffered and overrun set
    for (int i = 0; i < 5; i++) push_byte(8'hA1 + 8'(i));
    read_byte(1'b0, d);
    rd_req = 1'b1;
    wait_ack(d);
    chk("t1_count_before_reset", 32'(count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t1_count", 32'(count), 32'h0);
    chk("t1_ack", 32'(rd_ack), 32'h0);
    chk("t1_overrun", 32'(overrun), 32'h0);
    rd_req = 1'b0;
    @(negedge clk);

`ifdef UART_RX_ECHO_EN
    // Echo held off by a busy transmitter, and it back-pressures reads
    tx_busy = 1'b1;
    push_byte(8'h5A);
    read_byte(1'b0, d);
    chk("t6_first_data", 32'(d), 32'h5A);
    push_byte(8'h77);
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_start_held", 32'(tx_start), 32'h0);
      chk("t6_ack_blocked", 32'(rd_ack), 32'h0);
    end
    tx_busy = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1;
    end
    chk("t6_start_seen", 32'(seen), 32'h1);
    chk("t6_tx_data", 32'(tx_data), 32'h5A);
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_ack_blocked_busy", 32'(rd_ack), 32'h0);
    end
    tx_busy = 1'b0;
    wait_ack(d);
    chk("t6_second_data", 32'(d), 32'h77);
    rd_req = 1'b0;
    repeat (8) @(negedge clk);
`endif

    // Randomised traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rx_valid = ($urandom_range(0, 99) < 35);
      rx_data  = 8'($urandom);
      clr      = ($urandom_range(0, 99) < 5);
`ifdef UART_RX_ECHO_EN
      tx_busy  = ($urandom_range(0, 3) == 0);
`endif
      if (rd_req && rd_ack === 1'b1) begin
        if ($urandom_range(0, 3) == 0) hold = 1;
        else rd_req = 1'b0;
      end else if (rd_req && hold) begin
        hold = 0;
        rd_req = 1'b0;
      end else if (!rd_req) begin
        rd_req = ($urandom_range(0, 99) < 40);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0; clr = 1'b0; tx_busy = 1'b0;
    if (rd_req && rd_ack === 1'b1) @(negedge clk);
    rd_req = 1'b0;
    repeat (8) @(negedge clk);

    // Drain what is left
    for (int k = 0; k < DEPTH + 2 && m_q.size() > 0; k++) read_byte(1'b0, d);
    repeat (8) @(negedge clk);
    chk("drain_count", 32'(count), 32'h0);
    chk("drain_rd_pending", 32'(exp_rd_q.size()), 32'h0);
    chk("drain_tx_pending", 32'(exp_tx_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
